boot_imem: RTL and testbench

- Parameterised instruction memory for the single-cycle CPU; replaces the fixed 256-word ROM.
- CPU side: word-addressed fetch port from a byte address, with selectable combinational or registered read.
- Load side: a byte-stream loader (fed by the UART receiver) writes a new program into the array while holding the CPU in reset, then releases it.

---
 rtl/boot_imem.sv | 163 ++++++++++++++++
 tb/tb_boot_imem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_imem.sv
// Instruction memory for the single-cycle CPU with a UART-fed program loader.
// A framed byte stream (sync, 16-bit word count, data, checksum) rewrites the array while the CPU is held.
module boot_imem #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 31,
    parameter int READ_LAT = 0,
    parameter int BIG_END  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic              load_ovf
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef enum logic [2:0] {IDLE, HDRH, HDRL, DATA, CHK} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ptr_q, ptr_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  sum_q, sum_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        mem_we;
    logic [31:0] wr_word;

    // NOTE: the array has no reset; only its power-up value is defined, so a
    // reset mid-load leaves already written words in place.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    logic              accept;
    logic [ADDR_W-3:0] idx;
    logic              in_range;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    assign ld_ready  = 1'b1;
    assign accept    = ld_valid;
    assign cpu_hold  = (state_q != IDLE);
    assign load_done = done_q;
    assign load_err  = err_q;
    assign load_ovf  = ovf_q;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        sum_d   = sum_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        wr_word = (BIG_END != 0) ? {asm_q[23:0], ld_byte} : {ld_byte, asm_q[31:8]};

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (ld_byte == SYNC) begin
                        state_d = HDRH;
                        cnt_d   = '0;
                        ptr_d   = '0;
                        bcnt_d  = '0;
                        sum_d   = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                HDRH: begin
                    cnt_d[15:8] = ld_byte;
                    state_d     = HDRL;
                end
                HDRL: begin
                    cnt_d   = {cnt_q[15:8], ld_byte};
                    state_d = (cnt_d == 16'd0) ? CHK : DATA;
                end
                DATA: begin
                    sum_d  = sum_q + ld_byte;
                    asm_d  = wr_word;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Words past the end of the array are counted but dropped.
                        if (ptr_q < 16'(DEPTH)) mem_we = 1'b1;
                        else                    ovf_d  = 1'b1;
                        ptr_d = ptr_q + 16'd1;
                        if (ptr_d == cnt_q) state_d = CHK;
                    end
                end
                CHK: begin
                    err_d   = (ld_byte != sum_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) mem_q[ptr_q[IDX_W-1:0]] <= wr_word;
    end

    // Fetch: out-of-range indices and held CPU both read as NOP (zero).
    assign idx              = addr[ADDR_W-1:2];
    assign unused_addr_bits = ^addr[1:0];
    assign in_range         = ({1'b0, idx} < (ADDR_W-1)'(DEPTH));
    assign rd_word          = (cpu_hold || !in_range) ? 32'h0 : mem_q[idx[IDX_W-1:0]];

    generate
        if (READ_LAT == 1) begin : g_reg_read
            logic [31:0] rdata_q;
            always_ff @(posedge clk) begin
                if (!reset) rdata_q <= '0;
                else        rdata_q <= rd_word;
            end
            assign data = rdata_q;
        end else begin : g_comb_read
            assign data = rd_word;
        end
    endgenerate

endmodule

// File: tb/tb_boot_imem.sv
// Directed bench for boot_imem: a 256-word combinational-read instance and a
// 16-word registered-read, big-endian instance share stimulus, selected by sel.
module tb_boot_imem;

    logic        clk = 1'b0;
    logic        reset;
    logic [30:0] addr;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        sel;
    logic        valid_a, valid_b;

    logic [31:0] data_a, data_b;
    logic        ready_a, hold_a, done_a, err_a, ovf_a;
    logic        ready_b, hold_b, done_b, err_b, ovf_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign valid_a = ld_valid & ~sel;
    assign valid_b = ld_valid & sel;

    boot_imem #(.DEPTH(256), .ADDR_W(31), .READ_LAT(0), .BIG_END(0)) u_dut_a (
        .clk(clk), .reset(reset), .addr(addr), .data(data_a),
        .ld_byte(ld_byte), .ld_valid(valid_a), .ld_ready(ready_a),
        .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a), .load_ovf(ovf_a)
    );

    boot_imem #(.DEPTH(16), .ADDR_W(31), .READ_LAT(1), .BIG_END(1)) u_dut_b (
        .clk(clk), .reset(reset), .addr(addr), .data(data_b),
        .ld_byte(ld_byte), .ld_valid(valid_b), .ld_ready(ready_b),
        .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b), .load_ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All stimulus changes 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        ld_byte  = b;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic read_a(input logic [30:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, data_a, exp);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    logic [30:0] lag_addr [6];
    logic [31:0] lag_exp  [6];

    initial begin
        reset    = 1'b0;
        addr     = '0;
        ld_byte  = '0;
        ld_valid = 1'b0;
        sel      = 1'b0;
        #1;
        pulse_reset(2);

        // Reset values and power-up contents.
        check("rst_hold",  32'(hold_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_err",   32'(err_a),   32'd0);
        check("rst_ovf",   32'(ovf_a),   32'd0);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_ready_b", 32'(ready_b), 32'd1);
        check("rst_rdata_b", data_b, 32'h0);
        read_a(31'h000, "pwr_0",   32'h0);
        read_a(31'h004, "pwr_4",   32'h0);
        read_a(31'h3FC, "pwr_3fc", 32'h0);
        read_a(31'h400, "pwr_400", 32'h0);

        // Good little-endian load of two words.
        addr = 31'h0;
        check("pre_hold", 32'(hold_a), 32'd0);
        send(8'hA5, 0);
        check("sync_hold", 32'(hold_a), 32'd1);
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h20, 0); send(8'h00, 0); send(8'h08, 0); send(8'h20, 0);
        check("hold_nop", data_a, 32'h0);
        send(8'h08, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        check("pre_chk_hold", 32'(hold_a), 32'd1);
        check("pre_chk_done", 32'(done_a), 32'd0);
        send(8'h50, 0);
        check("good_done", 32'(done_a), 32'd1);
        check("good_hold", 32'(hold_a), 32'd0);
        check("good_err",  32'(err_a),  32'd0);
        check("good_ovf",  32'(ovf_a),  32'd0);
        tick();
        check("good_done_end", 32'(done_a), 32'd0);
        read_a(31'h000, "good_m0",   32'h20080020);
        read_a(31'h004, "good_m1",   32'h00000008);
        read_a(31'h007, "good_m1_lo", 32'h00000008);
        read_a(31'h400, "good_oor",  32'h0);

        // Bad checksum: words land, error sticks.
        send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        send(8'h65, 0);
        check("bad_done", 32'(done_a), 32'd1);
        check("bad_err",  32'(err_a),  32'd1);
        tick();
        check("bad_done_end", 32'(done_a), 32'd0);
        read_a(31'h000, "bad_m0", 32'h44332211);
        read_a(31'h004, "bad_m1", 32'h88776655);
        send(8'h00, 0);
        send(8'hFF, 0);
        check("garbage_hold", 32'(hold_a), 32'd0);
        check("bad_err_sticky", 32'(err_a), 32'd1);

        // Reset after six data bytes of a two-word load.
        send(8'hA5, 0);
        check("sync_clr_err", 32'(err_a), 32'd0);
        send(8'h00, 0); send(8'h02, 0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        send(8'hEE, 0); send(8'hFF, 0);
        pulse_reset(1);
        check("midrst_hold", 32'(hold_a), 32'd0);
        read_a(31'h000, "midrst_m0", 32'hDDCCBBAA);
        read_a(31'h004, "midrst_m1", 32'h88776655);
        send(8'h01, 0);
        check("midrst_idle", 32'(hold_a), 32'd0);

        // Zero-length load with a wrong checksum.
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
        check("zero_hold", 32'(hold_a), 32'd1);
        send(8'h01, 0);
        check("zero_done", 32'(done_a), 32'd1);
        check("zero_err",  32'(err_a),  32'd1);

        // Following full load completes normally.
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h0A, 0);
        check("reload_done", 32'(done_a), 32'd1);
        check("reload_err",  32'(err_a),  32'd0);
        read_a(31'h000, "reload_m0", 32'h04030201);
        read_a(31'h004, "reload_m1", 32'h88776655);

        // Instance B: garbage in IDLE, then overflowing load with gaps.
        sel = 1'b1;
        send(8'h00, 1);
        send(8'hFF, 1);
        check("b_garbage_hold", 32'(hold_b), 32'd0);
        send(8'hA5, 1); send(8'h00, 1); send(8'h11, 1);
        for (int i = 0; i < 68; i++) begin
            send(8'(i), 1);
            if (i == 40) check("b_mid_hold", 32'(hold_b), 32'd1);
        end
        check("b_pre_chk_ovf", 32'(ovf_b), 32'd1);
        send(8'hE6, 0);
        check("b_done", 32'(done_b), 32'd1);
        check("b_ovf",  32'(ovf_b),  32'd1);
        check("b_err",  32'(err_b),  32'd0);
        check("b_hold", 32'(hold_b), 32'd0);
        tick();
        check("b_done_end", 32'(done_b), 32'd0);

        // Registered read: data trails addr by exactly one cycle.
        lag_addr = '{31'h00, 31'h04, 31'h08, 31'h3C, 31'h40, 31'h00};
        lag_exp  = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h3C3D3E3F,
                     32'h0, 32'h00010203};
        addr = lag_addr[0];
        tick();
        for (int i = 1; i < 6; i++) begin
            addr = lag_addr[i];
            #1;
            check($sformatf("b_lag_%0d", i), data_b, lag_exp[i-1]);
            tick();
        end
        check("b_lag_last", data_b, lag_exp[5]);

        // Reset clears flags and the read register, not the array.
        pulse_reset(1);
        check("b_rst_ovf",   32'(ovf_b), 32'd0);
        check("b_rst_rdata", data_b, 32'h0);
        tick();
        check("b_rst_keep", data_b, 32'h00010203);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
